// File: rtl/mux_rr_sequencer_pkg.sv
// Shared definitions for the round-robin mux sequencer: selector idle code,
// FSM state encoding, source count and small decode helpers.
package mux_rr_sequencer_pkg;

  localparam logic [1:0] SEL_IDLE = 2'b11;
  localparam int         NUM_SRC  = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Beat counter width: ceil(log2(burst)) but never narrower than one bit.
  function automatic int cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

  // One-hot grant vector for a selector code; the idle code decodes to zero.
  function automatic logic [NUM_SRC-1:0] sel_decode(input logic [1:0] sel);
    logic [NUM_SRC-1:0] g;
    case (sel)
      2'd0:    g = 3'b001;
      2'd1:    g = 3'b010;
      2'd2:    g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  // Request bit of the source addressed by a selector code; idle code reads 0.
  function automatic logic req_of(input logic [NUM_SRC-1:0] req, input logic [1:0] sel);
    logic r;
    case (sel)
      2'd0:    r = req[0];
      2'd1:    r = req[1];
      2'd2:    r = req[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next source in circular order (mod 3); code 3 behaves like source 2.
  function automatic logic [1:0] rr_next(input logic [1:0] ptr);
    logic [1:0] n;
    case (ptr)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      2'd2:    n = 2'd0;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mux_rr_sequencer_pick.sv
// Combinational circular-priority picker: searches ptr+1, ptr+2, ptr+3 (mod 3)
// and reports the first requesting source.
module mux_rr_pick
  import mux_rr_sequencer_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand0_s;
  logic [1:0] cand1_s;
  logic [1:0] cand2_s;

  // Candidate search order, starting just after the pointer.
  always_comb begin
    cand0_s = rr_next(ptr);
    cand1_s = rr_next(cand0_s);
    cand2_s = rr_next(cand1_s);
  end

  // First requesting candidate wins; idle code when nobody requests.
  always_comb begin
    found = 1'b0;
    idx   = SEL_IDLE;
    if (req_of(req, cand0_s)) begin
      found = 1'b1;
      idx   = cand0_s;
    end else if (req_of(req, cand1_s)) begin
      found = 1'b1;
      idx   = cand1_s;
    end else if (req_of(req, cand2_s)) begin
      found = 1'b1;
      idx   = cand2_s;
    end else begin
      found = 1'b0;
      idx   = SEL_IDLE;
    end
  end

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer driving the 3-input data mux selector. Each grant is
// held for up to BURST accepted beats or until its request drops; on release
// the next requester takes over with no idle bubble.
module mux_rr_sequencer
  import mux_rr_sequencer_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               ready,
  output logic [1:0]         selector,
  output logic [NUM_SRC-1:0] grant,
  output logic               sel_valid,
  output logic               last_beat
);

  localparam int          CW       = cnt_width(BURST);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [1:0]         selector_r;
  logic [1:0]         selector_nxt_s;
  logic [NUM_SRC-1:0] grant_r;
  logic [NUM_SRC-1:0] grant_nxt_s;
  logic               sel_valid_r;
  logic               sel_valid_nxt_s;
  logic [CW-1:0]      beat_cnt_r;
  logic [CW-1:0]      beat_cnt_nxt_s;
  logic [1:0]         last_ptr_r;
  logic [1:0]         last_ptr_nxt_s;

  logic               transfer_s;
  logic               final_beat_s;
  logic               release_s;
  logic [1:0]         pick_ptr_s;
  logic               found_s;
  logic [1:0]         idx_s;

  // Handshake, release condition and picker pointer selection.
  always_comb begin
    transfer_s   = sel_valid_r & ready;
    final_beat_s = (beat_cnt_r == LAST_CNT);
    release_s    = (state_r == ST_GRANT) &
                   ((transfer_s & final_beat_s) | ~req_of(req, selector_r));
    // While granted, the current source becomes lowest priority.
    if (state_r == ST_GRANT) begin
      pick_ptr_s = selector_r;
    end else begin
      pick_ptr_s = last_ptr_r;
    end
  end

  mux_rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr_s),
    .found (found_s),
    .idx   (idx_s)
  );

  // State and output registers; reset forces idle and source 0 first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      selector_r  <= SEL_IDLE;
      grant_r     <= 3'b000;
      sel_valid_r <= 1'b0;
      beat_cnt_r  <= '0;
      last_ptr_r  <= 2'd2;
    end else begin
      state_r     <= state_nxt_s;
      selector_r  <= selector_nxt_s;
      grant_r     <= grant_nxt_s;
      sel_valid_r <= sel_valid_nxt_s;
      beat_cnt_r  <= beat_cnt_nxt_s;
      last_ptr_r  <= last_ptr_nxt_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s && !found_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, beat counter and priority pointer.
  always_comb begin
    selector_nxt_s  = selector_r;
    grant_nxt_s     = grant_r;
    sel_valid_nxt_s = sel_valid_r;
    beat_cnt_nxt_s  = beat_cnt_r;
    last_ptr_nxt_s  = last_ptr_r;
    case (state_r)
      ST_IDLE: begin
        beat_cnt_nxt_s = '0;
        if (found_s) begin
          selector_nxt_s  = idx_s;
          grant_nxt_s     = sel_decode(idx_s);
          sel_valid_nxt_s = 1'b1;
        end else begin
          selector_nxt_s  = SEL_IDLE;
          grant_nxt_s     = 3'b000;
          sel_valid_nxt_s = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          last_ptr_nxt_s = selector_r;
          beat_cnt_nxt_s = '0;
          if (found_s) begin
            selector_nxt_s  = idx_s;
            grant_nxt_s     = sel_decode(idx_s);
            sel_valid_nxt_s = 1'b1;
          end else begin
            selector_nxt_s  = SEL_IDLE;
            grant_nxt_s     = 3'b000;
            sel_valid_nxt_s = 1'b0;
          end
        end else if (transfer_s) begin
          beat_cnt_nxt_s = beat_cnt_r + CW'(1);
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
      end
      default: begin
        selector_nxt_s  = SEL_IDLE;
        grant_nxt_s     = 3'b000;
        sel_valid_nxt_s = 1'b0;
        beat_cnt_nxt_s  = '0;
        last_ptr_nxt_s  = 2'd2;
      end
    endcase
  end

  assign selector  = selector_r;
  assign grant     = grant_r;
  assign sel_valid = sel_valid_r;
  assign last_beat = sel_valid_r & (beat_cnt_r == LAST_CNT);

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Scoreboard bench for mux_rr_sequencer: one instance with BURST=4 and one
// with BURST=1. Stimulus pushes expected beats; negedge monitors pop and
// compare every accepted beat. Per-cycle status is checked directly.
module tb_mux_rr_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_a, req_b;
  logic       ready_a, ready_b;
  logic [1:0] sel_a, sel_b;
  logic [2:0] grant_a, grant_b;
  logic       valid_a, valid_b;
  logic       last_a, last_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] qa[$];
  logic [5:0] qb[$];
  logic [5:0] exp_a, exp_b;

  logic [6:0] st_a, st_b;
  localparam logic [6:0] IDLE = 7'b11_000_0_0;

  assign st_a = {sel_a, grant_a, valid_a, last_a};
  assign st_b = {sel_b, grant_b, valid_b, last_b};

  always #5 clk = ~clk;

  mux_rr_sequencer #(.BURST(4)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .ready(ready_a),
    .selector(sel_a), .grant(grant_a), .sel_valid(valid_a), .last_beat(last_a)
  );

  mux_rr_sequencer #(.BURST(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .ready(ready_b),
    .selector(sel_b), .grant(grant_b), .sel_valid(valid_b), .last_beat(last_b)
  );

  // Expected accepted beat: {selector, one-hot grant, last_beat}.
  function automatic logic [5:0] beat(input logic [1:0] sel, input logic last);
    logic [2:0] g;
    g = 3'b001 << sel;
    return {sel, g, last};
  endfunction

  // Expected status while granted: {selector, grant, sel_valid=1, last_beat}.
  function automatic logic [6:0] stat(input logic [1:0] sel, input logic last);
    logic [2:0] g;
    g = 3'b001 << sel;
    return {sel, g, 1'b1, last};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the BURST=4 instance.
  always @(negedge clk) begin
    if (!reset && valid_a && ready_a) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL beat_a: got unexpected beat %b, expected none", {sel_a, grant_a, last_a});
      end else begin
        exp_a = qa.pop_front();
        if ({sel_a, grant_a, last_a} !== exp_a) begin
          n_fail++;
          $display("FAIL beat_a: got %b, expected %b", {sel_a, grant_a, last_a}, exp_a);
        end
      end
    end
  end

  // Scoreboard monitor for the BURST=1 instance.
  always @(negedge clk) begin
    if (!reset && valid_b && ready_b) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL beat_b: got unexpected beat %b, expected none", {sel_b, grant_b, last_b});
      end else begin
        exp_b = qb.pop_front();
        if ({sel_b, grant_b, last_b} !== exp_b) begin
          n_fail++;
          $display("FAIL beat_b: got %b, expected %b", {sel_b, grant_b, last_b}, exp_b);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_a = 3'b000; ready_a = 1'b0; req_b = 3'b000; ready_b = 1'b0;
    #1;
    check("reset_a", st_a, IDLE);
    check("reset_b", st_b, IDLE);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // No requests: both stay idle.
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_a", st_a, IDLE);
      check("idle_b", st_b, IDLE);
    end

    // All three requesting: bursts 0,1,2,0 of 4 beats, back to back.
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++)
        qa.push_back(beat(2'(r % 3), b == 3));
    req_a = 3'b111; ready_a = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      check("rr3_status", st_a, stat(2'(((i - 1) / 4) % 3), ((i - 1) % 4) == 3));
    end
    req_a = 3'b000; ready_a = 1'b0;
    cyc();
    check("rr3_end_idle", st_a, IDLE);

    // Single requester: regranted back to back, sel_valid never drops.
    for (int b = 0; b < 12; b++) qa.push_back(beat(2'd1, (b % 4) == 3));
    req_a = 3'b010; ready_a = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      check("solo_status", st_a, stat(2'd1, ((i - 1) % 4) == 3));
    end
    req_a = 3'b000; ready_a = 1'b0;
    cyc();
    check("solo_end_idle", st_a, IDLE);

    // Stalled consumer: source 0 held with beat count stuck at 0.
    req_a = 3'b011; ready_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("stall_hold", st_a, stat(2'd0, 1'b0));
    end
    for (int b = 0; b < 4; b++) qa.push_back(beat(2'd0, b == 3));
    ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("stall_resume", st_a, (i == 4) ? stat(2'd1, 1'b0) : stat(2'd0, i == 3));
    end
    req_a = 3'b000; ready_a = 1'b0;
    cyc();
    check("stall_end_idle", st_a, IDLE);

    // Source 2 granted, request dropped after two beats: source 0 next, count restarts.
    qa.push_back(beat(2'd2, 1'b0));
    qa.push_back(beat(2'd2, 1'b0));
    req_a = 3'b101; ready_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("drop_src2", st_a, stat(2'd2, 1'b0));
    end
    req_a = 3'b001; ready_a = 1'b0;
    cyc();
    check("drop_switch", st_a, stat(2'd0, 1'b0));
    for (int b = 0; b < 4; b++) qa.push_back(beat(2'd0, b == 3));
    ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("drop_burst", st_a, stat(2'd0, i == 3));
    end
    // Drop together with a transfer: that beat still counts.
    qa.push_back(beat(2'd0, 1'b0));
    req_a = 3'b000;
    cyc();
    check("drop_xfer_idle", st_a, IDLE);
    ready_a = 1'b0;

    // Reset in the middle of a grant clears outputs at once.
    req_a = 3'b001;
    cyc();
    check("pre_reset_grant", st_a, stat(2'd0, 1'b0));
    #3 reset = 1'b1;
    #1 check("mid_reset_a", st_a, IDLE);
    req_a = 3'b000;
    cyc();
    reset = 1'b0;
    cyc();
    check("post_reset_idle", st_a, IDLE);
    // Reset restores source 0 as first priority.
    req_a = 3'b111;
    cyc();
    check("post_reset_prio", st_a, stat(2'd0, 1'b0));
    req_a = 3'b000;
    cyc();
    check("post_reset_end", st_a, IDLE);

    // BURST=1: every transfer releases, sources 0 and 2 alternate.
    for (int b = 0; b < 8; b++) qb.push_back(beat((b % 2 == 0) ? 2'd0 : 2'd2, 1'b1));
    req_b = 3'b101; ready_b = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check("b1_status", st_b, stat((i % 2 == 1) ? 2'd0 : 2'd2, 1'b1));
    end
    req_b = 3'b000; ready_b = 1'b0;
    cyc();
    check("b1_end_idle", st_b, IDLE);

    repeat (2) cyc();
    check("qa_drained", 8'(qa.size()), 8'd0);
    check("qb_drained", 8'(qb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_sequencer.md
Name: mux_rr_sequencer

Overview:
- Upstream control stage for the 3-input, 8-bit data mux (selector codes 00/01/10 pick in1/in2/in3; code 11 is unused there).
- Arbitrates round-robin between three requesting sources and drives the mux selector, holding each grant for a burst of up to BURST accepted beats.
- A downstream consumer accepts each muxed beat with a valid/ready handshake.
- Selector code 2'b11 is the idle code; the consumer ignores mux output whenever sel_valid is low.

Parameters:
- BURST, 4, maximum beats per grant; legal range 1..16. Counter width is derived internally, ceil(log2(BURST)) with a minimum of 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  3  level request per source; bit i maps to selector code i
- ready  input  1  consumer accepts the current beat
- selector  output  2  mux select; 2'b11 when idle
- grant  output  3  one-hot grant matching selector; 3'b000 when idle
- sel_valid  output  1  a beat is presented on the mux output
- last_beat  output  1  current beat is the final beat of the burst

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high.
- selector, grant and sel_valid are registered. last_beat is combinational from registers only: sel_valid AND (beat_cnt == BURST-1).
- Reset values: selector=2'b11, grant=3'b000, sel_valid=0, beat_cnt=0, last_ptr=2, state=IDLE. Reset with last_ptr=2 gives source 0 first priority.
- Reset asserted mid-burst clears everything immediately, with no completion of the beat in progress.
- Transfer: a cycle with sel_valid=1 and ready=1. beat_cnt increments on each transfer.
- Picker: combinational circular priority over req, searching order last_ptr+1, last_ptr+2, last_ptr+3 (mod 3). Result is a found flag and idx[1:0].
- States: IDLE, GRANT.
- IDLE, req==0: stay in IDLE; outputs stay idle.
- IDLE, any req bit set: next edge enters GRANT with selector=idx, grant=1<<idx, sel_valid=1, beat_cnt=0. Latency is 1 cycle from req to the grant being visible.
- GRANT, release condition: (transfer AND beat_cnt==BURST-1) OR (req[selector]==0). Request drop is checked every cycle, with or without a transfer.
- GRANT, on release: last_ptr<=selector, beat_cnt<=0.
- On release, the picker runs with last_ptr replaced by the current selector, so the current source is lowest priority. If it finds a requester, GRANT moves to the new idx on the next edge with no idle bubble; this includes regranting the same source if it is the only one requesting. If none is found, go to IDLE with selector=2'b11, grant=0, sel_valid=0.
- GRANT, no release: hold selector and grant. ready low holds the grant indefinitely while req stays high.
- Simultaneous events: a transfer on the final beat together with a req drop is a single release, counted once. A req drop in the same cycle as a transfer counts the beat as transferred.
- Requests from non-granted sources never preempt a burst.
- BURST=1: every transfer releases.
- Invariant: grant is zero or one-hot and always equals the decode of selector when sel_valid=1.

Decomposition:
- Shared Verilog include (mux_defs.vh):
  - SEL_IDLE=2'b11
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - NUM_SRC=3
- One natural sub-module: mux_rr_pick.
  - Purely combinational.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once, with ptr muxed between last_ptr (in IDLE) and selector (on release).

Test Plan:
- Reset, then req=3'b000 for 5 cycles -> selector=2'b11, grant=000, sel_valid=0 throughout; assert reset mid-burst -> outputs return to idle within the same cycle.
- req=3'b111, ready=1, BURST=4 -> grants in order 00 (4 beats), 01 (4), 10 (4), 00 again; last_beat high on every 4th transfer; no idle cycle between bursts.
- req=3'b010 only, ready=1 -> selector=01 regranted back-to-back; sel_valid stays 1 continuously.
- Source 0 granted, ready=0 for 10 cycles, req=3'b011 -> selector stays 00 and beat_cnt stays 0; raise ready -> 4 beats complete, then selector=01.
- Source 2 granted, drop req[2] after 2 transfers, req[0]=1 -> selector=00 on the next edge, beat_cnt=0.
- BURST=1, req=3'b101, ready=1 -> selector alternates 00,10,00,10 each cycle; last_beat constantly 1.
